// File: rtl/seq_gen_pkg.sv
// Shared constants and state encoding for the serial pattern generator.
package seq_gen_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_W_DEF = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StShift = S_SHIFT,
    StGap   = S_GAP,
    StFin   = S_FIN
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first; zeros fill from the LSB side.
module piso_shift_reg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] load_data,
  output logic             serial_out
);

  logic [PAT_W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (clr) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift_en) begin
      sr_q <= {sr_q[PAT_W-2:0], 1'b0};
    end
  end

  assign serial_out = sr_q[PAT_W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeat_n times,
// separated by gap idle-0 bits, then pulses done.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sr_clr, sr_load, sr_shift;
  logic [PAT_W-1:0] sr_data;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    pat_d     = pat_q;
    sr_clr    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d     = pattern;
          gap_len_d = gap;
          rep_cnt_d = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          bit_cnt_d = '0;
          sr_load   = 1'b1;
          sr_data   = pattern;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (abort) begin
          sr_clr  = 1'b1;
          state_d = StIdle;
        end else if (bit_cnt_q != LAST_BIT) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sr_shift  = 1'b1;
        end else begin
          bit_cnt_d = '0;
          if (rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - 1'b1;
          // Shifting out the last bit leaves the register all-zero, so x_out idles low.
          if (rep_cnt_q <= CNT_W'(1)) begin
            sr_shift = 1'b1;
            state_d  = StFin;
          end else if (gap_len_q == '0) begin
            sr_load = 1'b1;
          end else begin
            sr_shift  = 1'b1;
            gap_cnt_d = gap_len_q;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (abort) begin
          sr_clr  = 1'b1;
          state_d = StIdle;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          sr_load   = 1'b1;
          state_d   = StShift;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    x_valid_d = (state_d == StShift);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      pat_q     <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      pat_q     <= pat_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  piso_shift_reg #(
    .PAT_W(PAT_W)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .clr       (sr_clr),
    .load      (sr_load),
    .shift_en  (sr_shift),
    .load_data (sr_data),
    .serial_out(x_out)
  );

  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a per-cycle expected-output scoreboard.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] repeat_n;
  logic [3:0] gap;
  logic       x_out;
  logic       x_valid;
  logic       busy;
  logic       done;

  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  sequence_generator #(
    .PAT_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .repeat_n(repeat_n),
    .gap     (gap),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] e);
    exp_q.push_back(e);
  endtask

  // Expected {x_out, x_valid, busy, done} per cycle for one whole transfer.
  task automatic push_transfer(input logic [3:0] pat, input int reps, input int gp);
    int r;
    r = (reps == 0) ? 1 : reps;
    for (int i = 0; i < r; i++) begin
      for (int b = 3; b >= 0; b--) push({pat[b], 3'b110});
      if (i < r - 1) begin
        for (int g = 0; g < gp; g++) push(4'b0010);
      end
    end
    push(4'b0011);
    push(4'b0000);
  endtask

  task automatic check_one(input string tag);
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk);
    obs = {x_out, x_valid, busy, done};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed x/v/b/d=%b expected %b", tag, obs, exp);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) check_one(tag);
  endtask

  // Called at a negedge with the DUT idle; scrambles inputs after capture.
  task automatic run(input string tag, input logic [3:0] pat, input int reps, input int gp,
                     input logic with_abort);
    pattern  = pat;
    repeat_n = 8'(reps);
    gap      = 4'(gp);
    start    = 1'b1;
    abort    = with_abort;
    push_transfer(pat, reps, gp);
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    pattern  = ~pat;
    repeat_n = 8'd5;
    gap      = 4'd7;
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    pattern  = 4'b1111;
    repeat_n = 8'd1;
    gap      = 4'd0;

    push(4'b0000); check_one("reset_0");
    push(4'b0000); check_one("reset_1");
    reset = 1'b1;
    start = 1'b0;
    push(4'b0000); check_one("idle_after_reset");

    abort = 1'b1;
    push(4'b0000); check_one("abort_in_idle");
    abort = 1'b0;

    run("t1_1011_r1_g0", 4'b1011, 1, 0, 1'b0);
    run("t2_1011_r3_g2", 4'b1011, 3, 2, 1'b0);
    run("t3_1101_r2_g0", 4'b1101, 2, 0, 1'b0);
    run("t4_1000_r0", 4'b1000, 0, 0, 1'b0);

    // Start held high through the transfer, abort on the second bit.
    pattern  = 4'b1011;
    repeat_n = 8'd3;
    gap      = 4'd1;
    start    = 1'b1;
    push(4'b1110);
    @(posedge clk);
    #1;
    check_one("t5_bit1");
    push(4'b0110); check_one("t5_bit2");
    abort = 1'b1;
    start = 1'b0;
    push(4'b0000); check_one("t5_after_abort");
    abort = 1'b0;
    push(4'b0000); check_one("t5_idle");
    run("t5_restart_start_and_abort", 4'b1011, 1, 0, 1'b1);

    // Abort during a gap.
    pattern  = 4'b1001;
    repeat_n = 8'd2;
    gap      = 4'd3;
    start    = 1'b1;
    push(4'b1110); push(4'b0110); push(4'b0110); push(4'b1110); push(4'b0010);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t_gap_pre_abort");
    abort = 1'b1;
    push(4'b0000); check_one("t_gap_abort");
    abort = 1'b0;
    push(4'b0000); check_one("t_gap_abort_idle");

    // Reset on the third bit; start during reset must not be taken.
    pattern  = 4'b1011;
    repeat_n = 8'd1;
    gap      = 4'd0;
    start    = 1'b1;
    push(4'b1110); push(4'b0110); push(4'b1110);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t6_pre_reset");
    reset = 1'b0;
    start = 1'b1;
    push(4'b0000); check_one("t6_in_reset_0");
    push(4'b0000); check_one("t6_in_reset_1");
    reset = 1'b1;
    start = 1'b0;
    push(4'b0000); check_one("t6_idle_after_reset");
    run("t6_clean_0110_r2_g1", 4'b0110, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
